// File: rtl/pdcache_if.sv
// Bus interfaces for pdcache: datapath side and memory (caches) side.
interface datapath_cache_if;
  logic        halt, dmemREN, dmemWEN, dhit, flushed;
  logic [31:0] dmemaddr, dmemstore, dmemload;

  modport dcache (input halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
                  output dhit, dmemload, flushed);
  modport dp     (output halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
                  input dhit, dmemload, flushed);
endinterface

interface caches_if;
  logic        dwait, dREN, dWEN;
  logic [31:0] dload, daddr, dstore;

  modport dcache (input dwait, dload, output dREN, dWEN, daddr, dstore);
  modport mem    (output dwait, dload, input dREN, dWEN, daddr, dstore);
endinterface

// File: rtl/pdcache.sv
// pdcache: blocking write-back, set-associative data cache with age-based LRU,
// plus a halt-triggered flush. Define PDCACHE_HITCNT_EN to add a hit counter
// that is written to CNT_ADDR at the end of the flush.
module pdcache #(
  parameter int          SETS     = 8,
  parameter int          WAYS     = 2,
  parameter int          BLKWORDS = 2,
  parameter logic [31:0] CNT_ADDR = 32'h3100
) (
  input logic              CLK,
  input logic              n_rst,
  datapath_cache_if.dcache dcif,
  caches_if.dcache         cif
);
  localparam int IB = $clog2(SETS);
  localparam int OB = $clog2(BLKWORDS);
  localparam int TB = 30 - OB - IB;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = (BLKWORDS > 1) ? OB : 1;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_CHK, FLUSH_WB,
`ifdef PDCACHE_HITCNT_EN
    CNT_WR,
`endif
    DONE} state_e;

`ifdef PDCACHE_HITCNT_EN
  localparam state_e SCAN_END = CNT_WR;
  logic [31:0] cnt_q;
`else
  localparam state_e SCAN_END = DONE;
  logic unused_cnt_addr;
  assign unused_cnt_addr = ^CNT_ADDR;
`endif

  // frame storage
  logic          valid_q [SETS][WAYS];
  logic          dirty_q [SETS][WAYS];
  logic [TB-1:0] tag_q   [SETS][WAYS];
  logic [31:0]   data_q  [SETS][WAYS][BLKWORDS];
  logic [WW-1:0] age_q   [SETS][WAYS];

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [WW-1:0] vict_q, vict_d, fway_q, fway_d, fway_n;
  logic [TB-1:0] rtag_q, rtag_d;
  logic [IB-1:0] ridx_q, ridx_d, fset_q, fset_d, fset_n;
  logic          do_hit, miss, fill_wr, fill_done, flush_clr;

  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic [CW-1:0] woff;
  logic          req, hit, inv, wlast, flast;
  logic [WW-1:0] hway, victim, vmax, amax, hage;
  logic          unused_lsb;

  assign idx        = dcif.dmemaddr[2+OB +: IB];
  assign tag        = dcif.dmemaddr[31 -: TB];
  assign req        = dcif.dmemREN | dcif.dmemWEN;
  assign unused_lsb = ^dcif.dmemaddr[1:0];
  if (BLKWORDS > 1) begin : g_off
    assign woff = dcif.dmemaddr[2 +: OB];
  end else begin : g_nooff
    assign woff = '0;
  end

  function automatic logic [31:0] mkaddr(logic [TB-1:0] t, logic [IB-1:0] i, logic [CW-1:0] w);
    logic [31:0] a;
    a = (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB));
    if (BLKWORDS > 1) a = a | (32'(w) << 2);
    return a;
  endfunction

  assign wlast  = (wcnt_q == CW'(BLKWORDS - 1));
  assign flast  = (fset_q == IB'(SETS - 1)) && (fway_q == WW'(WAYS - 1));
  assign fway_n = (fway_q == WW'(WAYS - 1)) ? '0 : fway_q + WW'(1);
  assign fset_n = (fway_q == WW'(WAYS - 1)) ? fset_q + IB'(1) : fset_q;
  assign hage   = age_q[idx][hway];

  // tag match and victim choice for the addressed set (lowest invalid, else oldest)
  always_comb begin
    hit = 1'b0; hway = '0; inv = 1'b0; victim = '0; vmax = '0; amax = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin hit = 1'b1; hway = WW'(w); end
      if (!valid_q[idx][w]) begin inv = 1'b1; victim = WW'(w); end
    end
    for (int w = 0; w < WAYS; w++)
      if (age_q[idx][w] > amax) begin amax = age_q[idx][w]; vmax = WW'(w); end
    if (!inv) victim = vmax;
  end

  // controller state register
  always_ff @(posedge CLK or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE; wcnt_q <= '0; vict_q <= '0; rtag_q <= '0; ridx_q <= '0;
      fset_q <= '0; fway_q <= '0;
    end else begin
      state_q <= state_d; wcnt_q <= wcnt_d; vict_q <= vict_d; rtag_q <= rtag_d;
      ridx_q <= ridx_d; fset_q <= fset_d; fway_q <= fway_d;
    end

  // next state, bus outputs and array update strobes
  always_comb begin
    state_d = state_q; wcnt_d = wcnt_q; vict_d = vict_q; rtag_d = rtag_q; ridx_d = ridx_q;
    fset_d = fset_q; fway_d = fway_q;
    do_hit = 1'b0; miss = 1'b0; fill_wr = 1'b0; fill_done = 1'b0; flush_clr = 1'b0;
    dcif.dhit = 1'b0; dcif.dmemload = '0; dcif.flushed = 1'b0;
    cif.dREN = 1'b0; cif.dWEN = 1'b0; cif.daddr = '0; cif.dstore = '0;
    case (state_q)
      IDLE:
        if (dcif.halt) begin
          state_d = FLUSH_CHK; fset_d = '0; fway_d = '0;
        end else if (req && hit) begin
          do_hit = 1'b1; dcif.dhit = 1'b1; dcif.dmemload = data_q[idx][hway][woff];
        end else if (req) begin
          miss = 1'b1; vict_d = victim; rtag_d = tag; ridx_d = idx; wcnt_d = '0;
          state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WB : FILL;
        end
      WB: begin
        cif.dWEN   = 1'b1;
        cif.daddr  = mkaddr(tag_q[ridx_q][vict_q], ridx_q, wcnt_q);
        cif.dstore = data_q[ridx_q][vict_q][wcnt_q];
        if (!cif.dwait) begin
          wcnt_d = wlast ? '0 : wcnt_q + CW'(1);
          if (wlast) state_d = FILL;
        end
      end
      FILL: begin
        cif.dREN  = 1'b1;
        cif.daddr = mkaddr(rtag_q, ridx_q, wcnt_q);
        if (!cif.dwait) begin
          fill_wr = 1'b1;
          wcnt_d  = wlast ? '0 : wcnt_q + CW'(1);
          if (wlast) begin fill_done = 1'b1; state_d = IDLE; end
        end
      end
      FLUSH_CHK:
        if (dirty_q[fset_q][fway_q]) begin
          state_d = FLUSH_WB; wcnt_d = '0;
        end else if (flast) begin
          state_d = SCAN_END;
        end else begin
          fset_d = fset_n; fway_d = fway_n;
        end
      FLUSH_WB: begin
        cif.dWEN   = 1'b1;
        cif.daddr  = mkaddr(tag_q[fset_q][fway_q], fset_q, wcnt_q);
        cif.dstore = data_q[fset_q][fway_q][wcnt_q];
        if (!cif.dwait) begin
          wcnt_d = wlast ? '0 : wcnt_q + CW'(1);
          if (wlast) begin
            flush_clr = 1'b1;
            if (flast) state_d = SCAN_END;
            else begin state_d = FLUSH_CHK; fset_d = fset_n; fway_d = fway_n; end
          end
        end
      end
`ifdef PDCACHE_HITCNT_EN
      CNT_WR: begin
        cif.dWEN = 1'b1; cif.daddr = CNT_ADDR; cif.dstore = cnt_q;
        if (!cif.dwait) state_d = DONE;
      end
`endif
      DONE: dcif.flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // frame arrays: hit writes, fill data, tag install, age update, flush invalidate
  always_ff @(posedge CLK or negedge n_rst)
    if (!n_rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0; dirty_q[s][w] <= 1'b0; tag_q[s][w] <= '0; age_q[s][w] <= '0;
          for (int b = 0; b < BLKWORDS; b++) data_q[s][w][b] <= '0;
        end
    end else begin
      if (do_hit) begin
        if (dcif.dmemWEN) begin
          data_q[idx][hway][woff] <= dcif.dmemstore;
          dirty_q[idx][hway]      <= 1'b1;
        end
        for (int w = 0; w < WAYS; w++)
          if (WW'(w) == hway) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < hage) age_q[idx][w] <= age_q[idx][w] + WW'(1);
      end
      if (fill_wr) data_q[ridx_q][vict_q][wcnt_q] <= cif.dload;
      // A fill treats the victim as the oldest way, so every other way ages;
      // this turns the all-zero reset ages into a proper ordering as the set fills.
      if (fill_done) begin
        valid_q[ridx_q][vict_q] <= 1'b1;
        dirty_q[ridx_q][vict_q] <= 1'b0;
        tag_q[ridx_q][vict_q]   <= rtag_q;
        for (int w = 0; w < WAYS; w++)
          if (WW'(w) == vict_q) age_q[ridx_q][w] <= '0;
          else if (age_q[ridx_q][w] < WW'(WAYS - 1)) age_q[ridx_q][w] <= age_q[ridx_q][w] + WW'(1);
      end
      if (flush_clr) begin
        valid_q[fset_q][fway_q] <= 1'b0;
        dirty_q[fset_q][fway_q] <= 1'b0;
      end
    end

`ifdef PDCACHE_HITCNT_EN
  // +1 for every hit cycle served in IDLE, -1 once per miss
  always_ff @(posedge CLK or negedge n_rst)
    if (!n_rst)      cnt_q <= '0;
    else if (do_hit) cnt_q <= cnt_q + 32'd1;
    else if (miss)   cnt_q <= cnt_q - 32'd1;
`endif

endmodule

// File: tb/tb_pdcache.sv
// Directed bench for pdcache (default parameters).
module tb_pdcache;
  logic CLK = 1'b0;
  logic n_rst;
  always #5 CLK = ~CLK;

  datapath_cache_if dcif();
  caches_if         cif();

  pdcache dut (.CLK(CLK), .n_rst(n_rst), .dcif(dcif), .cif(cif));

  int tests = 0;
  int fails = 0;

  // memory model: one wait cycle per word, optional stall, transaction log
  logic [31:0] mem [0:255];
  int          lat = 0;
  logic        stall;
  logic        req;
  logic        log_we [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  assign req       = cif.dREN | cif.dWEN;
  assign cif.dwait = !(req && lat >= 1 && !stall);
  assign cif.dload = cif.dREN ? mem[cif.daddr[9:2]] : 32'h0;

  always @(posedge CLK) begin
    if (req && !cif.dwait) begin
      log_we.push_back(cif.dWEN);
      log_addr.push_back(cif.daddr);
      log_data.push_back(cif.dWEN ? cif.dstore : cif.dload);
      lat <= 0;
    end else if (req && !stall) lat <= lat + 1;
    else if (!req) lat <= 0;
  end

  task automatic do_reset;
    @(negedge CLK);
    n_rst = 1'b0; stall = 1'b0;
    dcif.halt = 1'b0; dcif.dmemREN = 1'b0; dcif.dmemWEN = 1'b0;
    dcif.dmemaddr = '0; dcif.dmemstore = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | (i << 2);
    @(negedge CLK);
    n_rst = 1'b1;
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic ok);
    ok = 1'b0; rd = '0;
    @(negedge CLK);
    dcif.dmemREN = !we; dcif.dmemWEN = we; dcif.dmemaddr = a; dcif.dmemstore = wd;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (dcif.dhit) begin ok = 1'b1; rd = dcif.dmemload; break; end
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    dcif.dmemREN = 1'b0; dcif.dmemWEN = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; stall = 1'b0; dcif.halt = 1'b0;
    dcif.dmemREN = 1'b1; dcif.dmemWEN = 1'b0; dcif.dmemaddr = 32'h100; dcif.dmemstore = '0;
    @(negedge CLK); #1;
    tests++; if (dcif.dhit !== 1'b0) begin fails++; $display("FAIL reset_dhit: got %b want 0", dcif.dhit); end
    tests++; if ({cif.dREN, cif.dWEN} !== 2'b00) begin fails++; $display("FAIL reset_ren_wen: got %b want 00", {cif.dREN, cif.dWEN}); end
    tests++; if (cif.daddr !== 32'h0) begin fails++; $display("FAIL reset_daddr: got %h want 0", cif.daddr); end
    tests++; if (dcif.flushed !== 1'b0) begin fails++; $display("FAIL reset_flushed: got %b want 0", dcif.flushed); end
    dcif.dmemREN = 1'b0;
    @(negedge CLK); n_rst = 1'b1;
    @(negedge CLK); #1;
    tests++; if ({cif.dREN, cif.dWEN, cif.daddr, cif.dstore, dcif.dmemload} !== '0) begin
      fails++; $display("FAIL post_reset_outputs: got %b/%b %h %h %h want all 0", cif.dREN, cif.dWEN, cif.daddr, cif.dstore, dcif.dmemload); end
  endtask

  task automatic test_cold_read;
    logic [31:0] rd; logic ok; int base;
    do_reset;
    mem[64] = 32'hA; mem[65] = 32'hB;
    base = log_addr.size();
    access(1'b0, 32'h100, '0, rd, ok);
    tests++; if (ok !== 1'b1 || rd !== 32'hA) begin fails++; $display("FAIL cold_read: got ok=%b %h want ok=1 0000000a", ok, rd); end
    tests++; if (log_addr.size() - base !== 2) begin fails++; $display("FAIL cold_fill_count: got %0d want 2", log_addr.size() - base); end
    tests++; if (log_we[base] !== 1'b0 || log_addr[base] !== 32'h100 || log_addr[base+1] !== 32'h104) begin
      fails++; $display("FAIL cold_fill_addrs: got we=%b %h %h want we=0 100 104", log_we[base], log_addr[base], log_addr[base+1]); end
    base = log_addr.size();
    access(1'b0, 32'h104, '0, rd, ok);
    tests++; if (ok !== 1'b1 || rd !== 32'hB) begin fails++; $display("FAIL read_104: got ok=%b %h want ok=1 0000000b", ok, rd); end
    tests++; if (log_addr.size() !== base) begin fails++; $display("FAIL read_104_traffic: got %0d want 0", log_addr.size() - base); end
  endtask

  task automatic test_lru;
    logic [31:0] rd; logic ok; int base;
    do_reset;
    access(1'b0, 32'h100, '0, rd, ok);
    access(1'b0, 32'h140, '0, rd, ok);
    access(1'b0, 32'h100, '0, rd, ok);
    base = log_addr.size();
    access(1'b0, 32'h180, '0, rd, ok);
    tests++; if (ok !== 1'b1 || rd !== 32'hC000_0180) begin fails++; $display("FAIL lru_read_180: got ok=%b %h want ok=1 c0000180", ok, rd); end
    tests++; if (log_addr.size() - base !== 2 || log_we[base] !== 1'b0 || log_we[base+1] !== 1'b0) begin
      fails++; $display("FAIL lru_no_wb: got %0d txns we=%b%b want 2 reads", log_addr.size() - base, log_we[base], log_we[base+1]); end
    base = log_addr.size();
    access(1'b0, 32'h100, '0, rd, ok);
    tests++; if (ok !== 1'b1 || log_addr.size() !== base) begin fails++; $display("FAIL lru_kept_100: got ok=%b txns=%0d want ok=1 0", ok, log_addr.size() - base); end
    base = log_addr.size();
    access(1'b0, 32'h140, '0, rd, ok);
    tests++; if (log_addr.size() - base !== 2) begin fails++; $display("FAIL lru_evicted_140: got %0d txns want 2", log_addr.size() - base); end
  endtask

  task automatic test_writeback;
    logic [31:0] rd; logic ok; int base;
    do_reset;
    mem[64] = 32'hA; mem[65] = 32'hB;
    access(1'b0, 32'h100, '0, rd, ok);
    base = log_addr.size();
    access(1'b1, 32'h100, 32'hDEAD, rd, ok);
    tests++; if (ok !== 1'b1 || log_addr.size() !== base) begin fails++; $display("FAIL write_hit: got ok=%b txns=%0d want ok=1 0", ok, log_addr.size() - base); end
    access(1'b0, 32'h140, '0, rd, ok);
    base = log_addr.size();
    access(1'b0, 32'h180, '0, rd, ok);
    tests++; if (log_addr.size() - base !== 4) begin fails++; $display("FAIL wb_count: got %0d want 4", log_addr.size() - base); end
    tests++; if (log_we[base] !== 1'b1 || log_addr[base] !== 32'h100 || log_data[base] !== 32'hDEAD) begin
      fails++; $display("FAIL wb_word0: got we=%b %h=%h want we=1 100=0000dead", log_we[base], log_addr[base], log_data[base]); end
    tests++; if (log_we[base+1] !== 1'b1 || log_addr[base+1] !== 32'h104 || log_data[base+1] !== 32'hB) begin
      fails++; $display("FAIL wb_word1: got we=%b %h=%h want we=1 104=0000000b", log_we[base+1], log_addr[base+1], log_data[base+1]); end
    tests++; if (log_we[base+2] !== 1'b0 || log_addr[base+2] !== 32'h180 || log_addr[base+3] !== 32'h184) begin
      fails++; $display("FAIL wb_then_fill: got we=%b %h %h want we=0 180 184", log_we[base+2], log_addr[base+2], log_addr[base+3]); end
    access(1'b1, 32'h1C4, 32'hBEEF, rd, ok);
    base = log_addr.size();
    access(1'b0, 32'h1C4, '0, rd, ok);
    tests++; if (ok !== 1'b1 || rd !== 32'hBEEF || log_addr.size() !== base) begin
      fails++; $display("FAIL write_miss_merge: got ok=%b %h txns=%0d want ok=1 0000beef 0", ok, rd, log_addr.size() - base); end
    access(1'b0, 32'h1C0, '0, rd, ok);
    tests++; if (rd !== 32'hC000_01C0) begin fails++; $display("FAIL merge_other_word: got %h want c00001c0", rd); end
  endtask

  task automatic test_stall;
    logic [31:0] rd; logic ok; logic seen; int base;
    do_reset;
    base = log_addr.size();
    @(negedge CLK);
    dcif.dmemREN = 1'b1; dcif.dmemaddr = 32'h200;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cif.dREN && cif.daddr == 32'h204) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL stall_reach_word1: got %b want 1", seen); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      tests++; if (cif.daddr !== 32'h204 || cif.dREN !== 1'b1 || dcif.dhit !== 1'b0) begin
        fails++; $display("FAIL stall_hold%0d: got %h ren=%b hit=%b want 00000204 ren=1 hit=0", i, cif.daddr, cif.dREN, dcif.dhit); end
    end
    stall = 1'b0;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); #1;
      if (dcif.dhit) begin ok = 1'b1; rd = dcif.dmemload; break; end
    end
    @(posedge CLK); #1;
    dcif.dmemREN = 1'b0;
    tests++; if (ok !== 1'b1 || rd !== 32'hC000_0200) begin fails++; $display("FAIL stall_complete: got ok=%b %h want ok=1 c0000200", ok, rd); end
    tests++; if (log_addr.size() - base !== 2 || log_addr[base+1] !== 32'h204) begin
      fails++; $display("FAIL stall_txns: got %0d last=%h want 2 00000204", log_addr.size() - base, log_addr[base+1]); end
  endtask

  task automatic test_flush;
    logic [31:0] rd; logic ok; int base; int exp_n;
    do_reset;
    access(1'b1, 32'h100, 32'h11, rd, ok);
    access(1'b1, 32'h108, 32'h22, rd, ok);
    base = log_addr.size();
    @(negedge CLK);
    dcif.halt = 1'b1; dcif.dmemREN = 1'b1; dcif.dmemaddr = 32'h100;
    #1;
    tests++; if (dcif.dhit !== 1'b0) begin fails++; $display("FAIL halt_priority: got dhit=%b want 0", dcif.dhit); end
    @(posedge CLK); #1;
    dcif.dmemREN = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #1;
      if (dcif.flushed) begin ok = 1'b1; break; end
    end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL flushed: got %b want 1", ok); end
    tests++; if ({cif.dREN, cif.dWEN} !== 2'b00) begin fails++; $display("FAIL done_idle_bus: got %b want 00", {cif.dREN, cif.dWEN}); end
`ifdef PDCACHE_HITCNT_EN
    exp_n = 5;
`else
    exp_n = 4;
`endif
    tests++; if (log_addr.size() - base !== exp_n) begin fails++; $display("FAIL flush_count: got %0d want %0d", log_addr.size() - base, exp_n); end
    tests++; if (log_addr[base] !== 32'h100 || log_data[base] !== 32'h11 || log_addr[base+1] !== 32'h104 || log_data[base+1] !== 32'hC000_0104) begin
      fails++; $display("FAIL flush_set0: got %h=%h %h=%h want 100=11 104=c0000104", log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]); end
    tests++; if (log_addr[base+2] !== 32'h108 || log_data[base+2] !== 32'h22 || log_addr[base+3] !== 32'h10C || log_data[base+3] !== 32'hC000_010C) begin
      fails++; $display("FAIL flush_set1: got %h=%h %h=%h want 108=22 10c=c000010c", log_addr[base+2], log_data[base+2], log_addr[base+3], log_data[base+3]); end
    tests++; if (log_we[base] !== 1'b1 || log_we[base+3] !== 1'b1) begin fails++; $display("FAIL flush_are_writes: got %b%b want 11", log_we[base], log_we[base+3]); end
`ifdef PDCACHE_HITCNT_EN
    tests++; if (log_addr[base+4] !== 32'h3100 || log_data[base+4] !== 32'h0 || log_we[base+4] !== 1'b1) begin
      fails++; $display("FAIL hitcnt_write: got we=%b %h=%h want we=1 3100=0", log_we[base+4], log_addr[base+4], log_data[base+4]); end
`endif
  endtask

  task automatic test_reset_mid_wb;
    logic [31:0] rd; logic ok; logic seen; int base;
    do_reset;
    access(1'b1, 32'h100, 32'h55, rd, ok);
    access(1'b0, 32'h140, '0, rd, ok);
    @(negedge CLK);
    dcif.dmemREN = 1'b1; dcif.dmemaddr = 32'h180;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cif.dWEN) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    tests++; if (seen !== 1'b1 || cif.daddr !== 32'h100) begin fails++; $display("FAIL mid_wb_reach: got %b %h want 1 00000100", seen, cif.daddr); end
    @(negedge CLK);
    n_rst = 1'b0;
    #1;
    tests++; if ({cif.dREN, cif.dWEN, dcif.dhit} !== 3'b000 || cif.daddr !== 32'h0 || cif.dstore !== 32'h0) begin
      fails++; $display("FAIL mid_wb_reset_outputs: got %b%b%b %h %h want 000 0 0", cif.dREN, cif.dWEN, dcif.dhit, cif.daddr, cif.dstore); end
    dcif.dmemREN = 1'b0;
    @(negedge CLK); n_rst = 1'b1;
    base = log_addr.size();
    access(1'b0, 32'h100, '0, rd, ok);
    tests++; if (ok !== 1'b1 || rd !== 32'hC000_0100 || log_addr.size() - base !== 2) begin
      fails++; $display("FAIL post_reset_miss: got ok=%b %h txns=%0d want ok=1 c0000100 2", ok, rd, log_addr.size() - base); end
  endtask

  initial begin
    n_rst = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | (i << 2);
    test_reset;
    test_cold_read;
    test_lru;
    test_writeback;
    test_stall;
    test_flush;
    test_reset_mid_wb;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
